hilo_mult_unit: RTL and testbench

- Multi-cycle shift-add multiplier that owns the HI/LO register pair for the MIPS datapath.
- Sits in EX beside the ALU. Executes multu (and, optionally, mult), then holds the 64-bit product in HI/LO.
- The mfhi/mflo ALU operations consume HI/LO.
- Asserts busy so the hazard/stall logic freezes the pipeline while a product is being computed.

---
 rtl/hilo_mult_unit.sv | 145 ++++++++++++++
 tb/tb_hilo_mult_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_unit.sv
// Shift-add HI/LO multiplier for the MIPS EX stage; one product bit per cycle.
// Optional signed multiply (funct F_MULT) is enabled by defining SIGNED_MULT_EN.
module hilo_mult_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [5:0]  F_MULTU = 6'd25,
    parameter logic [5:0]  F_MULT  = 6'd24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH-1:0] op_a, op_b;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    product;

`ifdef SIGNED_MULT_EN
    logic sign_q, sign_d;
    logic is_signed;

    // Signed operands enter the datapath as magnitudes; the sign is reapplied at the end.
    assign is_signed = (Funct == F_MULT);
    assign accept    = start && ((Funct == F_MULTU) || is_signed);
    assign op_a      = (is_signed && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    assign op_b      = (is_signed && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
    assign product   = sign_q ? (PW'(0) - acc_sum) : acc_sum;
`else
    assign accept    = start && (Funct == F_MULTU);
    assign op_a      = a;
    assign op_b      = b;
    assign product   = acc_sum;
`endif

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : PW'(0));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SIGNED_MULT_EN
        sign_d   = sign_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mcand_d  = PW'(op_a);
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                    busy_d   = 1'b1;
`ifdef SIGNED_MULT_EN
                    sign_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // HI/LO are only touched on the last iteration so mfhi/mflo stay stable.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    hi_d    = product[PW-1:WIDTH];
                    lo_d    = product[WIDTH-1:0];
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SIGNED_MULT_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SIGNED_MULT_EN
            sign_q   <= sign_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed self-checking bench for hilo_mult_unit with a queue of expected products.
module tb_hilo_mult_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  Funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_hilo = 64'h0;

    hilo_mult_unit dut (
        .clk(clk), .rst(rst), .start(start), .Funct(Funct),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one start pulse at the current negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [5:0] f,
                         input bit will_accept, input bit sgn);
        logic [63:0] ea, eb;
        ea = sgn ? {{32{ia[31]}}, ia} : {32'h0, ia};
        eb = sgn ? {{32{ib[31]}}, ib} : {32'h0, ib};
        start = 1'b1; Funct = f; a = ia; b = ib;
        if (will_accept) exp_q.push_back(ea * eb);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follow an accepted multiply to its done cycle; optionally pulse start mid-flight.
    task automatic collect(input string tag, input int inject);
        int n;
        bit hold_bad;
        logic [63:0] e;
        n = 0; hold_bad = 1'b0;
        chk({tag, "_busy_e0"}, 64'(busy), 64'h1);
        while (busy && n < 100) begin
            if ({hi, lo} !== model_hilo) hold_bad = 1'b1;
            if (inject != 0 && n == inject) begin
                start = 1'b1; a = 32'd2; b = 32'd2;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(done), 64'h1);
        chk({tag, "_hold"}, 64'(hold_bad), 64'h0);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 64'(exp_q.size()), 64'h1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_hilo"}, {hi, lo}, e);
            model_hilo = e;
        end
    endtask

    task automatic check_ignored(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_hilo"}, {hi, lo}, model_hilo);
    endtask

    initial begin
        bit done_seen;
        rst = 1'b1; start = 1'b0; Funct = 6'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'd3, 32'd5, 6'd25, 1'b1, 1'b0);
        collect("small", 0);
        @(negedge clk);
        chk("small_done_pulse", 64'(done), 64'h0);
        chk("small_val", {hi, lo}, 64'h0000_0000_0000_000F);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd25, 1'b1, 1'b0);
        collect("max", 0);
        chk("max_val", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);

        issue(32'd7, 32'd6, 6'd25, 1'b1, 1'b0);
        collect("busy_start", 10);
        chk("busy_start_lo", 64'(lo), 64'd42);
        @(negedge clk);
        chk("busy_start_idle", 64'(busy), 64'h0);

        issue(32'd4, 32'd4, 6'd32, 1'b0, 1'b0);
        check_ignored("bad_funct");

        issue(32'd11, 32'd13, 6'd25, 1'b1, 1'b0);
        collect("pre_b2b", 0);
        issue(32'd2, 32'd3, 6'd25, 1'b1, 1'b0);
        collect("b2b", 0);
        chk("b2b_lo", 64'(lo), 64'd6);
        @(negedge clk);

`ifdef SIGNED_MULT_EN
        issue(32'hFFFF_FFFE, 32'd3, 6'd24, 1'b1, 1'b1);
        collect("s_neg", 0);
        chk("s_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd24, 1'b1, 1'b1);
        collect("s_m1", 0);
        chk("s_m1_val", {hi, lo}, 64'h0000_0000_0000_0001);
        issue(32'h8000_0000, 32'd2, 6'd24, 1'b1, 1'b1);
        collect("s_min", 0);
        chk("s_min_val", {hi, lo}, 64'hFFFF_FFFF_0000_0000);
        @(negedge clk);
`else
        issue(32'hFFFF_FFFE, 32'd3, 6'd24, 1'b0, 1'b1);
        check_ignored("mult_off");
`endif

        issue(32'd9, 32'd9, 6'd25, 1'b1, 1'b0);
        repeat (14) @(negedge clk);
        chk("mid_busy_before_rst", 64'(busy), 64'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_done", 64'(done), 64'h0);
        chk("mid_rst_hilo", {hi, lo}, 64'h0);
        void'(exp_q.pop_front());
        model_hilo = 64'h0;
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        chk("mid_no_done", 64'(done_seen), 64'h0);
        chk("mid_hilo_after", {hi, lo}, 64'h0);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
